// File: rtl/multipack_pkg.sv
// Shared definitions for the multipack frame serialiser.
// Holds the default frame geometry and the FSM state type.
// Imported by multipack_reader.
package multipack_pkg;

  // Default frame geometry: five 11-bit words per frame
  localparam int WORDS_DEF = 5;
  localparam int WIDTH_DEF = 11;
  localparam int TOTAL     = WORDS_DEF * WIDTH_DEF;

  // IDLE waits for a frame, SHIFT streams it out one bit per handshake
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/multipack_reader.sv
// Serialises a frame of WORDS x WIDTH-bit words, MSB of the top word first.
// Latency: first bit is valid the cycle after the frame is accepted.
// Backpressure: out_ready=0 freezes the stream; the next frame is taken on the last-bit handshake.
module multipack_reader
  import multipack_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [WORDS],
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [7:0]       frame_count
);

  localparam int FTOTAL = WORDS * WIDTH;
  localparam int IDXW   = $clog2(FTOTAL);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FTOTAL - 1);

  state_t              state;
  logic [FTOTAL-1:0]   shreg;
  logic [FTOTAL-1:0]   load_vec;
  logic [IDXW-1:0]     idx;
  logic                out_fire;
  logic                last_fire;
  logic                accept;

  // Flatten the word array so word WORDS-1 sits in the top bits of the shift register
  always_comb begin
    load_vec = '0;
    for (int w = 0; w < WORDS; w++) begin
      load_vec[w*WIDTH +: WIDTH] = in_data[w];
    end
  end

  // Outputs come straight from registered state and are forced low when idle
  assign out_valid = (state == SHIFT);
  assign out_last  = out_valid & (idx == LAST_IDX);
  assign out_bit   = out_valid & shreg[FTOTAL-1];

  assign out_fire  = out_valid & out_ready;
  assign last_fire = out_fire & out_last;

  // A new frame may enter when idle, or in the same cycle the final bit leaves
  assign in_ready  = reset_n & ((state == IDLE) | last_fire);
  assign accept    = in_valid & in_ready;

  // Frame load, bit shifting, FSM and completed-frame counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      shreg       <= '0;
      frame_count <= 8'd0;
    end else begin
      if (last_fire) begin
        frame_count <= frame_count + 8'd1;
      end
      if (accept) begin
        shreg <= load_vec;
        idx   <= '0;
        state <= SHIFT;
      end else if (last_fire) begin
        shreg <= {shreg[FTOTAL-2:0], 1'b0};
        idx   <= '0;
        state <= IDLE;
      end else if (out_fire) begin
        shreg <= {shreg[FTOTAL-2:0], 1'b0};
        idx   <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multipack_reader.sv
// Self-checking bench for multipack_reader using a bit-level scoreboard.
// Frames are queued, expected bits are pushed on acceptance and popped on each output handshake.
// Per-cycle checks cover valid, in_ready, idle outputs, stall stability and frame_count.
module tb_multipack_reader;

  localparam int WORDS = 5;
  localparam int WIDTH = 11;

  typedef logic [WORDS-1:0][WIDTH-1:0] frame_t;
  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data [WORDS];
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [7:0]       frame_count;

  int       errors = 0;
  int       checks = 0;
  int       vcnt   = 0;
  int       rdy_mode = 0;
  logic [7:0] exp_fc = 8'd0;
  frame_t   frames [$];
  exp_t     sb [$];

  multipack_reader #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected serial order: top word first, each word MSB first
  task automatic push_frame(input frame_t f);
    exp_t e;
    for (int w = WORDS - 1; w >= 0; w--) begin
      for (int b = WIDTH - 1; b >= 0; b--) begin
        e.b    = f[w][b];
        e.last = (w == 0) && (b == 0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    frames.delete();
    exp_fc = 8'd0;
  endtask

  // Offers queued frames and consumes output until drained, max_hs handshakes, or budget cycles
  task automatic drive_frames(input string name, input int max_hs, input int budget);
    int   n;
    int   hs;
    bit   prev_stalled;
    logic pb;
    logic pl;
    logic exp_rdy;
    exp_t e;
    n = 0; hs = 0; vcnt = 0; prev_stalled = 0; pb = 0; pl = 0;
    while (1) begin
      @(negedge clock);
      if (frames.size() > 0) begin
        in_valid = 1'b1;
        for (int w = 0; w < WORDS; w++) in_data[w] = frames[0][w];
      end else begin
        in_valid = 1'b0;
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (vcnt % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      checks++;
      if (frame_count !== exp_fc) begin
        errors++;
        $display("FAIL %s frame_count: got %0d expected %0d", name, frame_count, exp_fc);
      end
      checks++;
      if (out_valid !== (sb.size() > 0)) begin
        errors++;
        $display("FAIL %s out_valid: got %b expected %b", name, out_valid, sb.size() > 0);
      end
      exp_rdy = (sb.size() == 0) || (out_ready && sb[0].last);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready: got %b expected %b", name, in_ready, exp_rdy);
      end
      if (out_valid !== 1'b1) begin
        checks++;
        if (out_bit !== 1'b0 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_outputs: got bit=%b last=%b expected 0/0", name, out_bit, out_last);
        end
      end
      if (prev_stalled) begin
        checks++;
        if (out_bit !== pb || out_last !== pl) begin
          errors++;
          $display("FAIL %s stall_hold: got bit=%b last=%b expected %b/%b", name, out_bit, out_last, pb, pl);
        end
      end
      if (out_valid === 1'b1) vcnt++;
      if (out_valid === 1'b1 && out_ready) begin
        hs++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_bit: got bit=%b expected no output", name, out_bit);
        end else begin
          e = sb.pop_front();
          if (out_bit !== e.b || out_last !== e.last) begin
            errors++;
            $display("FAIL %s bit%0d: got bit=%b last=%b expected %b/%b", name, hs, out_bit, out_last, e.b, e.last);
          end
          if (e.last) exp_fc = exp_fc + 8'd1;
        end
      end
      if (in_valid && in_ready === 1'b1) push_frame(frames.pop_front());
      prev_stalled = (out_valid === 1'b1) && !out_ready;
      pb = out_bit;
      pl = out_last;
      n++;
      if (frames.size() == 0 && sb.size() == 0) break;
      if (max_hs > 0 && hs >= max_hs) break;
      if (n >= budget) begin
        errors++;
        checks++;
        $display("FAIL %s timeout: got %0d cycles expected completion", name, n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int w = 0; w < WORDS; w++) in_data[w] = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got rdy=%b vld=%b last=%b expected 0/0/0", in_ready, out_valid, out_last);
    end
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b fc=%0d expected 1/0/0", in_ready, out_valid, frame_count);
    end
  endtask

  task automatic test_single();
    frame_t f;
    apply_reset();
    f = '0;
    f[4] = 11'h400;
    frames.push_back(f);
    rdy_mode = 0;
    drive_frames("single", 0, 200);
    @(negedge clock); #1;
    checks++;
    if (vcnt != 55 || frame_count !== 8'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got vcnt=%0d fc=%0d vld=%b expected 55/1/0", vcnt, frame_count, out_valid);
    end
  endtask

  task automatic test_toggle();
    frame_t f;
    apply_reset();
    f = '0;
    f[0] = 11'h001;
    frames.push_back(f);
    rdy_mode = 1;
    drive_frames("toggle", 0, 400);
    @(negedge clock); #1;
    checks++;
    if (vcnt != 109 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL toggle_done: got cycles=%0d fc=%0d expected 109/1", vcnt, frame_count);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    frames.push_back('1);
    frames.push_back('0);
    rdy_mode = 0;
    drive_frames("b2b", 0, 400);
    @(negedge clock); #1;
    checks++;
    if (vcnt != 110 || frame_count !== 8'd2) begin
      errors++;
      $display("FAIL b2b_done: got valid_cycles=%0d fc=%0d expected 110/2", vcnt, frame_count);
    end
  endtask

  task automatic test_mid_reset();
    frame_t f;
    apply_reset();
    for (int w = 0; w < WORDS; w++) f[w] = 11'($urandom);
    frames.push_back(f);
    rdy_mode = 0;
    drive_frames("midrst_a", 20, 200);
    @(negedge clock);
    reset_n   = 1'b0;
    out_ready = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_abort: got vld=%b last=%b rdy=%b fc=%0d expected 0/0/0/0", out_valid, out_last, in_ready, frame_count);
    end
    reset_n = 1'b1;
    sb.delete();
    exp_fc = 8'd0;
    for (int w = 0; w < WORDS; w++) f[w] = 11'($urandom);
    frames.push_back(f);
    drive_frames("midrst_b", 0, 200);
    @(negedge clock); #1;
    checks++;
    if (vcnt != 55 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL midrst_restart: got vcnt=%0d fc=%0d expected 55/1", vcnt, frame_count);
    end
  endtask

  task automatic test_wrap();
    frame_t f;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      for (int w = 0; w < WORDS; w++) f[w] = 11'($urandom);
      frames.push_back(f);
    end
    rdy_mode = 2;
    drive_frames("wrap", 0, 60000);
    @(negedge clock); #1;
    checks++;
    if (frame_count !== 8'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: got fc=%0d vld=%b expected 0/0", frame_count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_toggle();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
